edu_aqmeas_writer: RTL

//  Writer side of the EDU ancilla-measurement buffer. Collects per-round ancilla results from the

---
 rtl/edu_aqmeas_writer_pkg.sv | 17 +
 rtl/edu_aqmeas_writer_if.sv | 25 ++
 rtl/edu_aqmeas_writer_round_fifo.sv | 59 +++++
 rtl/edu_aqmeas_writer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/edu_aqmeas_writer_pkg.sv
// Shared types and default sizing for the EDU ancilla-measurement writer.
package edu_aqmeas_writer_pkg;

    localparam int DEF_NUM_AQ    = 32;
    localparam int DEF_CHUNK_BW  = 8;
    localparam int DEF_BUF_DEPTH = 4;
    localparam int DEF_ROUND_BW  = 4;
    localparam int DEF_AQMEAS_TH = 2;
    localparam int DEF_CODE_DIST = 5;

    typedef enum logic [1:0] {
        AQW_IDLE    = 2'd0,
        AQW_COLLECT = 2'd1,
        AQW_COMMIT  = 2'd2
    } aqw_state_e;

endpackage

// File: rtl/edu_aqmeas_writer_if.sv
// Measurement beat stream plus EDU-facing round-buffer read port.
interface edu_aqmeas_writer_if #(
    parameter int NUM_AQ   = 32,
    parameter int CHUNK_BW = 8,
    parameter int ROUND_BW = 4
);
    logic                meas_valid;
    logic [CHUNK_BW-1:0] meas_chunk;
    logic                meas_last;
    logic                meas_ready;
    logic                pop_aqmeasbuf;
    logic                aqmeas_valid;
    logic [NUM_AQ-1:0]   aqmeas_data;
    logic [ROUND_BW-1:0] aqmeas_counter;

    modport master (
        output meas_valid, meas_chunk, meas_last, pop_aqmeasbuf,
        input  meas_ready, aqmeas_valid, aqmeas_data, aqmeas_counter
    );

    modport slave (
        input  meas_valid, meas_chunk, meas_last, pop_aqmeasbuf,
        output meas_ready, aqmeas_valid, aqmeas_data, aqmeas_counter
    );
endinterface

// File: rtl/edu_aqmeas_writer_round_fifo.sv
// Round FIFO: WIDTH-bit words, DEPTH entries (power of 2), occupancy count, head read combinationally.
module edu_aqmeas_writer_round_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Masked while empty so the read port shows 0 out of reset instead of stale storage.
    assign head    = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; validity is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/edu_aqmeas_writer.sv
// EDU ancilla-measurement writer: packs beats into round words, feeds the round FIFO, tracks ESM rounds.
// Build option AQMEAS_DIFF_EN: push detection events (round XOR previous round) instead of raw rounds.
module edu_aqmeas_writer
    import edu_aqmeas_writer_pkg::*;
#(
    parameter int NUM_AQ    = DEF_NUM_AQ,
    parameter int CHUNK_BW  = DEF_CHUNK_BW,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int ROUND_BW  = DEF_ROUND_BW,
    parameter int AQMEAS_TH = DEF_AQMEAS_TH,
    parameter int CODE_DIST = DEF_CODE_DIST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                esm_start,
    edu_aqmeas_writer_if.slave  bus,
    output logic [ROUND_BW-1:0] round_counter,
    output logic                esm_rounds_done,
    output logic                framing_err,
    output logic                underflow_err
);
    localparam int BEATS  = NUM_AQ / CHUNK_BW;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [ROUND_BW-1:0] LAST_ROUND = ROUND_BW'(CODE_DIST - 1);

    if (BUF_DEPTH < AQMEAS_TH || (NUM_AQ % CHUNK_BW) != 0) begin : g_param_err
        $error("edu_aqmeas_writer: illegal NUM_AQ/CHUNK_BW/BUF_DEPTH combination");
    end

    aqw_state_e          state_q, state_d;
    logic [NUM_AQ-1:0]   pack_q, pack_d;
    logic [BEAT_W-1:0]   beat_idx_q, beat_idx_d;
    logic [ROUND_BW-1:0] round_q, round_d;
    logic                done_q, done_d;
    logic                framing_q, framing_d;
    logic                underflow_q, underflow_d;
    logic                push, fifo_full, fifo_empty, at_last_slot;
    logic [NUM_AQ-1:0]   push_word;

    assign at_last_slot = (beat_idx_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        beat_idx_d  = beat_idx_q;
        round_d     = round_q;
        done_d      = 1'b0;
        framing_d   = framing_q;
        underflow_d = underflow_q | (bus.pop_aqmeasbuf & fifo_empty);
        push        = 1'b0;
        case (state_q)
            AQW_IDLE: begin
                if (esm_start) begin
                    state_d = AQW_COLLECT;
                    round_d = '0;
                end
            end
            AQW_COLLECT: begin
                if (bus.meas_valid) begin
                    pack_d[int'(beat_idx_q) * CHUNK_BW +: CHUNK_BW] = bus.meas_chunk;
                    beat_idx_d = beat_idx_q + BEAT_W'(1);
                    if (bus.meas_last || at_last_slot) begin
                        state_d = AQW_COMMIT;
                        // Early last or a missing last both mean the beat count and framing disagree.
                        if (bus.meas_last != at_last_slot) framing_d = 1'b1;
                    end
                end
            end
            AQW_COMMIT: begin
                if (!fifo_full) begin
                    push       = 1'b1;
                    pack_d     = '0;
                    beat_idx_d = '0;
                    round_d    = round_q + ROUND_BW'(1);
                    if (round_q == LAST_ROUND) begin
                        done_d  = 1'b1;
                        state_d = AQW_IDLE;
                    end else begin
                        state_d = AQW_COLLECT;
                    end
                end
            end
            default: state_d = AQW_IDLE;
        endcase
    end

    // NOTE: every flop here is updated with non-blocking assignments from the _d values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= AQW_IDLE;
            pack_q      <= '0;
            beat_idx_q  <= '0;
            round_q     <= '0;
            done_q      <= 1'b0;
            framing_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pack_q      <= pack_d;
            beat_idx_q  <= beat_idx_d;
            round_q     <= round_d;
            done_q      <= done_d;
            framing_q   <= framing_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef AQMEAS_DIFF_EN
    logic [NUM_AQ-1:0] prev_round_q, prev_round_d;

    always_comb begin
        prev_round_d = prev_round_q;
        if (state_q == AQW_IDLE && esm_start) prev_round_d = '0;
        else if (push)                        prev_round_d = pack_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_round_q <= '0;
        else      prev_round_q <= prev_round_d;
    end

    assign push_word = pack_q ^ prev_round_q;
`else
    assign push_word = pack_q;
`endif

    edu_aqmeas_writer_round_fifo #(
        .WIDTH (NUM_AQ),
        .DEPTH (BUF_DEPTH),
        .CNT_W (ROUND_BW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (bus.pop_aqmeasbuf),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.aqmeas_counter),
        .head      (bus.aqmeas_data)
    );

    assign bus.meas_ready   = (state_q == AQW_COLLECT);
    assign bus.aqmeas_valid = ~fifo_empty;
    assign round_counter    = round_q;
    assign esm_rounds_done  = done_q;
    assign framing_err      = framing_q;
    assign underflow_err    = underflow_q;
endmodule
